// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC register, combinational imem fetch and a
// DEPTH-entry queue of {instruction, pc} feeding decode. Supports decode
// stall (deq_ready) and a jump redirect that flushes the queue.
// Optional build macro: FETCH_BYPASS_EN -- when the queue is empty the fetched
// word is presented to decode in the same cycle and may be consumed directly.
module fetch_queue_unit #(
   parameter int unsigned W        = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PC_STEP  = 1,
   parameter logic [W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [W-1:0]                 imem_addr,
   input  logic [W-1:0]                 imem_data,
   input  logic                         redirect_en,
   input  logic [W-1:0]                 redirect_pc,
   input  logic                         deq_ready,
   output logic                         inst_valid,
   output logic [W-1:0]                 inst,
   output logic [W-1:0]                 inst_pc,
   output logic [$clog2(DEPTH+1)-1:0]   q_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_queue_unit: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      logic [W-1:0] inst;
      logic [W-1:0] pc;
   } entry_t;

   logic [W-1:0]     pc;
   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   entry_t           head;
   logic             queue_empty;
   logic             queue_full;
   logic             deq_q;
   logic             fetch;
   logic             wr_en;
   logic             bypass_hit;

   assign imem_addr = pc;
   assign q_count   = count;

   // Head view, handshake decode and fetch/write enables.
   always_comb begin
      head        = mem[rd_ptr];
      queue_empty = (count == '0);
      queue_full  = (count == CNT_W'(DEPTH));
      inst_valid  = 1'b0;
      inst        = '0;
      inst_pc     = '0;
      bypass_hit  = 1'b0;
`ifdef FETCH_BYPASS_EN
      if (!queue_empty) begin
         inst_valid = 1'b1;
         inst       = head.inst;
         inst_pc    = head.pc;
      end else if (!redirect_en) begin
         // Empty queue: forward the word being fetched this cycle.
         inst_valid = 1'b1;
         inst       = imem_data;
         inst_pc    = pc;
         bypass_hit = deq_ready;
      end
`else
      if (!queue_empty) begin
         inst_valid = 1'b1;
         inst       = head.inst;
         inst_pc    = head.pc;
      end
`endif
      // Queue pop only; a bypass consume never touches the storage.
      deq_q = !queue_empty && deq_ready && !redirect_en;
      fetch = !redirect_en && (!queue_full || deq_q);
      wr_en = fetch && !bypass_hit;
   end

   // PC, pointers and occupancy; reset beats redirect, redirect beats traffic.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_en) begin
         pc     <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (fetch) pc     <= pc + W'(PC_STEP);
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq_q) rd_ptr <= rd_ptr + PTR_W'(1);
         if (wr_en && !deq_q)      count <= count + CNT_W'(1);
         else if (!wr_en && deq_q) count <= count - CNT_W'(1);
      end
   end

   // Queue storage; contents are only observed through count, so no reset.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem[wr_ptr] <= '{inst: imem_data, pc: pc};
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus random
// traffic checked against a queue-based behavioural model.
module tb_fetch_queue_unit;

   localparam int unsigned W = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [W-1:0] RESET_PC = '0;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  imem_addr, imem_data, redirect_pc, inst, inst_pc;
   logic          redirect_en, deq_ready, inst_valid;
   logic [2:0]    q_count;

   // Narrow instance for PC wrap-around.
   logic          rst8, deq8, v8;
   logic [7:0]    a8, d8, i8, p8;
   logic [2:0]    q8;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] inst;
      logic [W-1:0] pc;
   } ent_t;

   ent_t         mq[$];
   logic [W-1:0] m_pc;
   logic         e_valid;
   logic [W-1:0] e_inst, e_pc, e_addr;
   logic [2:0]   e_cnt;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_data = mem_word(imem_addr);
   assign d8 = a8 ^ 8'hA5;

   fetch_queue_unit #(.W(W), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .q_count(q_count)
   );

   fetch_queue_unit #(.W(8), .DEPTH(4), .PC_STEP(1), .RESET_PC(8'hFE)) dut8 (
      .clk(clk), .rst(rst8), .imem_addr(a8), .imem_data(d8),
      .redirect_en(1'b0), .redirect_pc(8'h00), .deq_ready(deq8),
      .inst_valid(v8), .inst(i8), .inst_pc(p8), .q_count(q8)
   );

   // Expected outputs for the current state and inputs.
   task automatic model_eval();
      if (mq.size() != 0) begin
         e_valid = 1'b1; e_inst = mq[0].inst; e_pc = mq[0].pc;
      end else if (BYP && !redirect_en) begin
         e_valid = 1'b1; e_inst = mem_word(m_pc); e_pc = m_pc;
      end else begin
         e_valid = 1'b0; e_inst = '0; e_pc = '0;
      end
      e_cnt  = 3'(mq.size());
      e_addr = m_pc;
   endtask

   // Advance the model by one clock edge using the current inputs.
   task automatic model_step();
      int unsigned n;
      bit take;
      if (!rst) begin
         mq.delete(); m_pc = RESET_PC;
      end else if (redirect_en) begin
         mq.delete(); m_pc = redirect_pc;
      end else begin
         n = mq.size();
         if (BYP && n == 0 && deq_ready) begin
            m_pc = m_pc + 1;
         end else begin
            take = (n != 0) && deq_ready;
            if (take) void'(mq.pop_front());
            if (n < DEPTH || take) begin
               mq.push_back('{inst: mem_word(m_pc), pc: m_pc});
               m_pc = m_pc + 1;
            end
         end
      end
   endtask

   task automatic adv();
      model_step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; redirect_en = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
      adv();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) rst = 1'b1;
         @(negedge clk); model_eval(); checks++;
         if ({inst_valid, inst, inst_pc, q_count, imem_addr} !== {e_valid, e_inst, e_pc, e_cnt, e_addr}) begin
            errors++;
            $display("FAIL reset k=%0d got v=%b i=%h p=%h c=%0d a=%h exp v=%b i=%h p=%h c=%0d a=%h",
                     k, inst_valid, inst, inst_pc, q_count, imem_addr, e_valid, e_inst, e_pc, e_cnt, e_addr);
         end
         adv();
      end
   endtask

   task automatic test_fill_stall();
      deq_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); model_eval(); checks++;
         if ({inst_valid, inst, inst_pc, q_count, imem_addr} !== {e_valid, e_inst, e_pc, e_cnt, e_addr}) begin
            errors++;
            $display("FAIL fill_stall k=%0d got v=%b p=%h c=%0d a=%h exp v=%b p=%h c=%0d a=%h",
                     k, inst_valid, inst_pc, q_count, imem_addr, e_valid, e_pc, e_cnt, e_addr);
         end
         adv();
      end
      checks++;
      if (q_count !== 3'd4 || imem_addr !== 32'd4) begin
         errors++;
         $display("FAIL full_hold got c=%0d a=%h exp c=4 a=4", q_count, imem_addr);
      end
   endtask

   task automatic test_stream_full();
      deq_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); model_eval(); checks++;
         if ({inst_valid, inst, inst_pc, q_count, imem_addr} !== {e_valid, e_inst, e_pc, e_cnt, e_addr}) begin
            errors++;
            $display("FAIL stream k=%0d got v=%b p=%h c=%0d a=%h exp v=%b p=%h c=%0d a=%h",
                     k, inst_valid, inst_pc, q_count, imem_addr, e_valid, e_pc, e_cnt, e_addr);
         end
         adv();
      end
   endtask

   task automatic test_redirect();
      rst = 1'b0; adv(); rst = 1'b1;
      deq_ready = 1'b0; adv(); adv(); adv();
      for (int k = 0; k < 5; k++) begin
         redirect_en = (k == 0);
         redirect_pc = 32'h40;
         deq_ready   = 1'b1;
         @(negedge clk); model_eval(); checks++;
         if ({inst_valid, inst, inst_pc, q_count, imem_addr} !== {e_valid, e_inst, e_pc, e_cnt, e_addr}) begin
            errors++;
            $display("FAIL redirect k=%0d got v=%b p=%h c=%0d a=%h exp v=%b p=%h c=%0d a=%h",
                     k, inst_valid, inst_pc, q_count, imem_addr, e_valid, e_pc, e_cnt, e_addr);
         end
         adv();
      end
      redirect_en = 1'b0;
   endtask

   task automatic test_reset_vs_redirect();
      deq_ready = 1'b0;
      while (mq.size() != 3) adv();
      for (int k = 0; k < 3; k++) begin
         rst = (k != 0); redirect_en = (k == 0); redirect_pc = 32'h80;
         @(negedge clk); model_eval(); checks++;
         if ({inst_valid, inst, inst_pc, q_count, imem_addr} !== {e_valid, e_inst, e_pc, e_cnt, e_addr}) begin
            errors++;
            $display("FAIL reset_vs_redirect k=%0d got v=%b p=%h c=%0d a=%h exp v=%b p=%h c=%0d a=%h",
                     k, inst_valid, inst_pc, q_count, imem_addr, e_valid, e_pc, e_cnt, e_addr);
         end
         adv();
      end
      rst = 1'b1; redirect_en = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         rst         = ($urandom_range(99) >= 2);
         redirect_en = ($urandom_range(99) < 8);
         redirect_pc = $urandom;
         deq_ready   = ($urandom_range(99) < 65);
         @(negedge clk); model_eval(); checks++;
         if ({inst_valid, inst, inst_pc, q_count, imem_addr} !== {e_valid, e_inst, e_pc, e_cnt, e_addr}) begin
            errors++;
            $display("FAIL random k=%0d got v=%b i=%h p=%h c=%0d a=%h exp v=%b i=%h p=%h c=%0d a=%h",
                     k, inst_valid, inst, inst_pc, q_count, imem_addr, e_valid, e_inst, e_pc, e_cnt, e_addr);
         end
         adv();
      end
      rst = 1'b1; redirect_en = 1'b0;
   endtask

   task automatic test_pc_wrap();
      logic [7:0] exp_pc;
      int consumed;
      logic exp_v;
      logic [2:0] exp_q;
      exp_pc = 8'hFE; consumed = 0;
      rst8 = 1'b0; deq8 = 1'b1;
      @(posedge clk); #1;
      rst8 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         exp_v = BYP || (k >= 1);
         exp_q = (BYP || k == 0) ? 3'd0 : 3'd1;
         checks++;
         if ({v8, q8} !== {exp_v, exp_q} || (v8 && {p8, i8} !== {exp_pc, exp_pc ^ 8'hA5})) begin
            errors++;
            $display("FAIL pc_wrap k=%0d got v=%b p=%h i=%h c=%0d exp v=%b p=%h i=%h c=%0d",
                     k, v8, p8, i8, q8, exp_v, exp_pc, exp_pc ^ 8'hA5, exp_q);
         end
         if (v8) begin
            exp_pc = exp_pc + 8'd1;
            consumed++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (consumed < 4) begin
         errors++;
         $display("FAIL pc_wrap_count got %0d exp >=4", consumed);
      end
   endtask

   initial begin
      rst8 = 1'b0; deq8 = 1'b0;
      mq.delete(); m_pc = RESET_PC;
      test_reset();
      test_fill_stall();
      test_stream_full();
      test_redirect();
      test_reset_vs_redirect();
      test_random();
      test_pc_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
